// File: rtl/downsample_ber_checker.sv
// downsample_ber_checker
//   Decimates a 4x oversampled RC-FIR output down to one sample per symbol,
//   slices it to a bit, searches for the reference alignment delay that gives
//   the fewest errors, then counts bits and bit errors at that delay.
//
// Ports
//   clock        system clock, rising edge
//   i_reset      asynchronous active-high reset
//   i_enable     valid oversampled sample on i_data (4 per symbol)
//   i_data       signed filter output sample
//   i_phase      which of the 4 samples per symbol is decimated
//   i_ref_bit    transmitted reference bit, sampled on each symbol strobe
//   i_clear      synchronous restart of alignment search and counters
//   o_bit        sliced symbol bit
//   o_bit_valid  one-cycle pulse qualifying o_bit
//   o_locked     high while counting at the chosen delay
//   o_delay      selected alignment delay
//   o_bit_count  symbols compared while locked (saturating)
//   o_err_count  mismatches while locked (saturating)
module downsample_ber_checker #(
  parameter  int NB_INPUT  = 8,
  parameter  int NB_COUNT  = 32,
  parameter  int N_DELAY   = 32,
  parameter  int ALIGN_LEN = 255,
  localparam int NB_DELAY  = (N_DELAY > 1) ? $clog2(N_DELAY) : 1,
  localparam int NB_WIN    = $clog2(ALIGN_LEN + 1)
) (
  input  logic                       clock,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic signed [NB_INPUT-1:0] i_data,
  input  logic        [1:0]          i_phase,
  input  logic                       i_ref_bit,
  input  logic                       i_clear,
  output logic                       o_bit,
  output logic                       o_bit_valid,
  output logic                       o_locked,
  output logic        [NB_DELAY-1:0] o_delay,
  output logic        [NB_COUNT-1:0] o_bit_count,
  output logic        [NB_COUNT-1:0] o_err_count
);

  typedef enum logic {S_SEARCH, S_COUNT} state_t;

  localparam logic [NB_WIN-1:0]   WIN_LAST = NB_WIN'(ALIGN_LEN - 1);
  localparam logic [NB_DELAY-1:0] DLY_LAST = NB_DELAY'(N_DELAY - 1);

  state_t                state_q, state_d;
  logic [1:0]            phase_cnt_q, phase_cnt_d;
  logic [N_DELAY-2:0]    ref_q, ref_d;
  logic [NB_DELAY-1:0]   dly_q, dly_d;
  logic [NB_DELAY-1:0]   best_d_q, best_d_d;
  logic [NB_WIN-1:0]     best_err_q, best_err_d;
  logic [NB_WIN-1:0]     win_cnt_q, win_cnt_d;
  logic [NB_WIN-1:0]     win_err_q, win_err_d;
  logic                  bit_q, bit_d;
  logic                  bit_vld_q, bit_vld_d;
  logic [NB_COUNT-1:0]   bit_cnt_q, bit_cnt_d;
  logic [NB_COUNT-1:0]   err_cnt_q, err_cnt_d;

  logic                  strobe;
  logic                  sliced;
  logic [N_DELAY-1:0]    taps;
  logic [NB_DELAY-1:0]   cur_dly;
  logic                  mismatch;
  logic [NB_WIN-1:0]     win_sum;

  function automatic logic [NB_COUNT-1:0] sat_inc(input logic [NB_COUNT-1:0] v,
                                                  input logic inc);
    logic [NB_COUNT-1:0] r;
    r = v;
    if (inc && (v != '1)) r = v + NB_COUNT'(1);
    return r;
  endfunction

  function automatic logic slice(input logic signed [NB_INPUT-1:0] s);
    return (s >= 0);
  endfunction

  assign strobe   = i_enable && (phase_cnt_q == i_phase);
  assign sliced   = slice(i_data);
  // Tap 0 is the reference bit arriving with the current strobe itself.
  assign taps     = {ref_q, i_ref_bit};
  assign cur_dly  = (state_q == S_COUNT) ? best_d_q : dly_q;
  assign mismatch = sliced ^ taps[cur_dly];

  always_comb begin
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q;
    ref_d       = ref_q;
    dly_d       = dly_q;
    best_d_d    = best_d_q;
    best_err_d  = best_err_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    bit_d       = bit_q;
    bit_vld_d   = strobe;
    bit_cnt_d   = bit_cnt_q;
    err_cnt_d   = err_cnt_q;
    win_sum     = win_err_q + NB_WIN'(mismatch);

    if (i_enable) phase_cnt_d = phase_cnt_q + 2'd1;

    if (strobe) begin
      bit_d = sliced;
      // Keeps shifting even across i_clear so the reference stays aligned
      // with the data stream for the next search.
      ref_d = taps[N_DELAY-2:0];
    end

    if (i_clear) begin
      state_d    = S_SEARCH;
      dly_d      = '0;
      best_d_d   = '0;
      best_err_d = '1;
      win_cnt_d  = '0;
      win_err_d  = '0;
      bit_cnt_d  = '0;
      err_cnt_d  = '0;
    end else if (strobe) begin
      case (state_q)
        S_SEARCH: begin
          if (win_cnt_q == WIN_LAST) begin
            // Strict less-than: ties keep the lower delay.
            if (win_sum < best_err_q) begin
              best_err_d = win_sum;
              best_d_d   = dly_q;
            end
            win_cnt_d = '0;
            win_err_d = '0;
            if (dly_q == DLY_LAST) begin
              dly_d   = '0;
              state_d = S_COUNT;
            end else begin
              dly_d = dly_q + NB_DELAY'(1);
            end
          end else begin
            win_cnt_d = win_cnt_q + NB_WIN'(1);
            win_err_d = win_sum;
          end
        end
        S_COUNT: begin
          bit_cnt_d = sat_inc(bit_cnt_q, 1'b1);
          err_cnt_d = sat_inc(err_cnt_q, mismatch);
        end
        default: state_d = S_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= S_SEARCH;
      phase_cnt_q <= '0;
      ref_q       <= '0;
      dly_q       <= '0;
      best_d_q    <= '0;
      best_err_q  <= '1;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      bit_q       <= 1'b0;
      bit_vld_q   <= 1'b0;
      bit_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      phase_cnt_q <= phase_cnt_d;
      ref_q       <= ref_d;
      dly_q       <= dly_d;
      best_d_q    <= best_d_d;
      best_err_q  <= best_err_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      bit_q       <= bit_d;
      bit_vld_q   <= bit_vld_d;
      bit_cnt_q   <= bit_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign o_bit       = bit_q;
  assign o_bit_valid = bit_vld_q;
  assign o_locked    = (state_q == S_COUNT);
  assign o_delay     = best_d_q;
  assign o_bit_count = bit_cnt_q;
  assign o_err_count = err_cnt_q;

endmodule
